// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [5:0] DEFAULT_HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM and
// buffers one instruction toward decode with a valid/ready handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ROM_BYTES   = 256,
  parameter logic [5:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [31:0]       rom_address,
  output logic              rom_read_enable,
  input  logic [INST_W-1:0] rom_read_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halt,
  output logic              fault
);

  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         bad_pc;
  logic         free;
  logic         load;

  // Load qualification: a fetch happens only from a legal PC into a free buffer.
  always_comb begin
    bad_pc = (pc[1:0] != 2'b00) || (pc > LAST_PC);
    free   = !inst_valid || inst_ready;
    load   = (state == FETCH) && !redirect_valid && !bad_pc && free;
  end

  assign rom_address     = pc;
  assign rom_read_enable = load;

  // PC, state, output buffer and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      halt       <= 1'b0;
      fault      <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything; in IDLE it only retargets the PC.
      pc <= redirect_pc;
      if (state != IDLE) begin
        state      <= FETCH;
        inst_valid <= 1'b0;
        halt       <= 1'b0;
        fault      <= 1'b0;
      end
    end else begin
      // A consume clears the buffer unless a load below refills it.
      if (inst_valid && inst_ready) begin
        inst_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (bad_pc) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (load) begin
            inst_data  <= rom_read_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + 32'd4;
            if (rom_read_data[31:26] == HALT_OPCODE) begin
              state <= HALTED;
              halt  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: constant vector table, directed
// corner-case sequences and a randomized run against a reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] rom_address;
  logic        rom_read_enable;
  logic [31:0] rom_read_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom [64];
  logic        last_ren;

  // Reference model: fetch mode 0=idle 1=fetching 2=halted 3=faulted
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_data;
  logic [31:0] m_ipc;

  always #5 clk = ~clk;

  always_comb begin
    if (rom_address < 32'd256) rom_read_data = rom[rom_address[7:2]];
    else                       rom_read_data = 32'hDEAD_BEEF;
  end

  fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .ROM_BYTES  (256),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .rom_address    (rom_address),
    .rom_read_enable(rom_read_enable),
    .rom_read_data  (rom_read_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fault          (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    w = rom[a[7:2]];
    return w;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_ipc   = 32'h0;
  endtask

  // One clock: drive inputs, check the fetch decision, advance model and DUT.
  task automatic cycle(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        illegal;
    logic        will_load;
    logic [31:0] w;
    int          prev;
    run = r; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    illegal   = (m_pc % 4 != 0) || (m_pc > 32'd252);
    will_load = (m_mode == 1) && !rv && !illegal && (!m_valid || rdy);
    last_ren  = rom_read_enable;
    check("ren", {31'b0, rom_read_enable}, {31'b0, will_load});
    check("addr_pre", rom_address, m_pc);
    w = model_word(m_pc);
    @(posedge clk);
    #1;
    prev = m_mode;
    if (rv) begin
      m_pc = rpc;
      if (prev != 0) begin
        m_mode  = 1;
        m_valid = 1'b0;
      end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (prev == 0 && r) m_mode = 1;
      else if (prev == 1 && illegal) m_mode = 3;
      else if (will_load) begin
        m_data  = w;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        if (w[31:26] == 6'h3F) m_mode = 2;
      end
    end
    check("valid", {31'b0, inst_valid}, {31'b0, m_valid});
    check("addr", rom_address, m_pc);
    check("data", inst_data, m_data);
    check("ipc", inst_pc, m_ipc);
    check("halt", {31'b0, halt}, {31'b0, m_mode == 2});
    check("fault", {31'b0, fault}, {31'b0, m_mode == 3});
  endtask

  task automatic reset_dut();
    run = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_addr", rom_address, 32'h0);
    check("rst_ren", {31'b0, rom_read_enable}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        run;
    logic        ready;
    logic        exp_ren;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    logic        exp_halt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,         32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h20010005,  32'h4, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h20020003,  32'h8, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 32'hFC000000,  32'hC, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'hFC000000,  32'hC, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'hFC000000,  32'hC, 1'b1};

    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013 + 32'(i << 8);
    rom[0] = 32'h2001_0005;
    rom[1] = 32'h2002_0003;
    rom[2] = 32'hFC00_0000;

    // Streaming table
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].run, tbl[i].ready, 1'b0, 32'h0);
      check($sformatf("tbl%0d_ren", i), {31'b0, last_ren}, {31'b0, tbl[i].exp_ren});
      check($sformatf("tbl%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_ipc", i), inst_pc, tbl[i].exp_ipc);
      check($sformatf("tbl%0d_data", i), inst_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_addr", i), rom_address, tbl[i].exp_addr);
      check($sformatf("tbl%0d_halt", i), {31'b0, halt}, {31'b0, tbl[i].exp_halt});
    end

    // Backpressure
    reset_dut();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("bp_ren", {31'b0, last_ren}, 32'h0);
      check("bp_data", inst_data, 32'h2001_0005);
      check("bp_ipc", inst_pc, 32'h0);
      check("bp_pc", rom_address, 32'h4);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_next_ipc", inst_pc, 32'h4);
    check("bp_next_valid", {31'b0, inst_valid}, 32'h1);

    // Redirect flushes the pending halt word from pc=8
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("pend8_ipc", inst_pc, 32'h8);
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    check("flush_valid", {31'b0, inst_valid}, 32'h0);
    check("flush_addr", rom_address, 32'h40);
    check("flush_halt", {31'b0, halt}, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("flush_ren", {31'b0, last_ren}, 32'h1);
    check("flush_ipc", inst_pc, 32'h40);

    // Misaligned redirect faults, later redirect recovers
    cycle(1'b0, 1'b1, 1'b1, 32'h42);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("mis_ren", {31'b0, last_ren}, 32'h0);
    check("mis_fault", {31'b0, fault}, 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h10);
    check("recover_fault", {31'b0, fault}, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("recover_ipc", inst_pc, 32'h10);

    // Running off the end of the ROM
    cycle(1'b0, 1'b1, 1'b1, 32'hF8);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("end_ipc", inst_pc, 32'hFC);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("end_fault", {31'b0, fault}, 32'h1);
    check("end_addr", rom_address, 32'h100);

    // Consume and redirect in the same cycle
    cycle(1'b0, 1'b1, 1'b1, 32'h80);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("sim_pre_valid", {31'b0, inst_valid}, 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'h20);
    check("sim_valid", {31'b0, inst_valid}, 32'h0);
    check("sim_addr", rom_address, 32'h20);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("sim_ipc", inst_pc, 32'h20);

    // Asynchronous reset while an instruction is pending
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, inst_valid}, 32'h0);
    check("arst_addr", rom_address, 32'h0);
    check("arst_data", inst_data, 32'h0);
    check("arst_ipc", inst_pc, 32'h0);
    check("arst_halt", {31'b0, halt}, 32'h0);
    check("arst_fault", {31'b0, fault}, 32'h0);
    check("arst_ren", {31'b0, rom_read_enable}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("idle_valid", {31'b0, inst_valid}, 32'h0);
    check("idle_addr", rom_address, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("rerun_ipc", inst_pc, 32'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 64; i++) begin
      rom[i] = $urandom;
      if ($urandom_range(0, 7) == 0) rom[i][31:26] = 6'h3F;
      else if (rom[i][31:26] == 6'h3F) rom[i][31:26] = 6'h00;
    end
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      logic        rr, rdy, rv;
      logic [31:0] rpc;
      int          sel;
      rr  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel == 7) rpc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 8) rpc = 32'h100 + 32'($urandom_range(0, 64) * 4);
      else               rpc = 32'hFFFF_FFFC;
      cycle(rr, rdy, rv, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences the byte-addressed, combinational instruction ROM of the single-cycle CPU. Each fetch drives the ROM address and read enable, then registers the returned 32-bit word into a one-entry output buffer with a valid/ready handshake toward decode. It also handles branch/jump redirects, a halt opcode, and out-of-range or misaligned PCs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- ROM_BYTES, 256, ROM size in bytes; the last legal fetch address is ROM_BYTES-4.
- HALT_OPCODE, 6'b111111, value of instruction bits [31:26] that stops fetching.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start fetching; sampled only in IDLE.
- rom_address  out  32  equals pc at all times.
- rom_read_enable  out  1  high only in a load cycle.
- rom_read_data  in  32  ROM word, valid in the same cycle as the address.
- inst_valid  out  1  output buffer holds an instruction.
- inst_ready  in  1  decode accepts the instruction.
- inst_data  out  32  buffered instruction word.
- inst_pc  out  32  byte address of inst_data.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  redirect target.
- halt  out  1  high while in HALTED.
- fault  out  1  high while in FAULT.

## Operation
- States: IDLE, FETCH, HALTED, FAULT.
- **bad_pc**: pc[1:0] != 0, or pc > ROM_BYTES-4 (unsigned compare).
- **free**: !inst_valid, or inst_valid && inst_ready.
- **load**: state==FETCH && !redirect_valid && !bad_pc && free.
  - In a load cycle: rom_read_enable=1; inst_data<=rom_read_data; inst_pc<=pc; inst_valid<=1; pc<=pc+4 (32-bit wrap, no saturation).
- **Consume without load**: inst_valid && inst_ready && !load clears inst_valid.
- **Redirect** is highest priority, in any state other than IDLE:
  - pc<=redirect_pc; inst_valid<=0 (this flushes a pending instruction, even one being accepted in the same cycle); state<=FETCH.
  - A redirect in IDLE updates pc and leaves the state at IDLE.
- IDLE -> FETCH when run=1. rom_read_enable is 0 in IDLE.
- FETCH -> FAULT when bad_pc and no redirect. There is no load in that cycle.
- FETCH -> HALTED when a load occurs and rom_read_data[31:26]==HALT_OPCODE.
  - The halt word itself is buffered and delivered to decode.
- HALTED and FAULT:
  - No ROM reads.
  - The pending inst_valid may still drain through the handshake.
  - Exit only by a redirect (to FETCH) or by reset.
- Output handshake:
  - inst_data and inst_pc stay stable while inst_valid && !inst_ready.
  - inst_valid never drops without a transfer, except on a redirect.

## Timing
- Reset values: pc=RESET_PC (so rom_address=RESET_PC), rom_read_enable=0, inst_valid=0, inst_data=0, inst_pc=0, halt=0, fault=0, state=IDLE.
- Reset asserted mid-stream takes effect immediately and asynchronously. Outputs go to their reset values without waiting for a clock edge.
- The first load happens in the cycle after run is sampled high. inst_valid rises on the following edge.
- Load-to-output latency is 1 cycle. With inst_ready held high, throughput is 1 instruction per cycle with no bubbles.
- A redirect in cycle N produces a load from redirect_pc in cycle N+1, and the instruction is visible in N+2.
- halt and fault assert on the edge that enters their state. Both are registered and glitch-free.
- Load and consume in the same cycle: the buffer is overwritten and inst_valid stays 1.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t enum: IDLE, FETCH, HALTED, FAULT.
  - Default HALT_OPCODE.
  - Width constant INST_W=32.
- No sub-modules; this is a single flat module.
- The instruction ROM is instantiated beside this block at CPU top level, with rom_* wired port-to-port.

## Test plan
- **Streaming**: ROM words at addresses 0,4,8 = 32'h20010005, 32'h20020003, 32'hFC000000; run=1; ready=1 -> inst_pc sequence 0,4,8 on consecutive cycles. After the word at 8 is loaded, halt=1 and rom_read_enable stays 0.
- **Backpressure**: ready=0 for 3 cycles after the first inst_valid -> inst_data/inst_pc held at 32'h20010005/0; pc stays 4 and there are no extra loads. On ready=1, the next instruction follows in the next cycle.
- **Redirect flush**: redirect_valid with redirect_pc=32'h40 while the word from pc=8 is pending -> the pending word is dropped. The next rom_address is 32'h40, and inst_pc=32'h40 two cycles after the redirect.
- **Fault**: redirect_pc=32'h42 -> fault=1 with no load. A second redirect to 32'h10 -> fault=0 and fetching resumes from 32'h10. Separately, fetching past ROM_BYTES-4=252 -> fault at pc=256.
- **Reset mid-stream**: drop rst_n while inst_valid=1 -> outputs go to their reset values immediately. After release, the block stays in IDLE until run; the first inst_pc after run is RESET_PC.
- **Simultaneous consume and redirect**: inst_valid=1, ready=1, redirect_valid=1 in one cycle -> the transfer counts as accepted, inst_valid=0 next cycle, and pc=redirect_pc.
